// File: rtl/shift_link_ctrl.sv
// Sequencer for a serial/parallel shift path: runs one NBITS-long TX (LSB first) or RX transfer per start.
// Latency: start edge to done pulse is NBITS+1 cycles; all outputs come from registered state.
module shift_link_ctrl #(
  parameter int NBITS = 4
) (
  input  logic                     clk_2,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     mode,
  input  logic                     abort,
  input  logic [NBITS-1:0]         data_in,
  input  logic                     serial_in,
  output logic                     serial_out,
  output logic [NBITS-1:0]         data_out,
  output logic                     busy,
  output logic                     done,
  output logic [1:0]               state_dbg,
  output logic [$clog2(NBITS)-1:0] count_dbg
);

  localparam int CW = $clog2(NBITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] shreg_q, shreg_d;
  logic [NBITS-1:0] data_out_q, data_out_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             mode_q, mode_d;
  logic             last_shift;

  assign last_shift = (cnt_q == CW'(NBITS - 1));

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT: begin
        if (abort)           state_d = IDLE;
        else if (last_shift) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy       = (state_q == SHIFT) || (state_q == DONE);
    done       = (state_q == DONE);
    serial_out = (state_q == SHIFT) && !mode_q && shreg_q[0];
    state_dbg  = state_q;
    count_dbg  = cnt_q;
    data_out   = data_out_q;
  end

  // Abort freezes the datapath; the next start reloads everything anyway.
  always_comb begin
    shreg_d    = shreg_q;
    data_out_d = data_out_q;
    cnt_d      = cnt_q;
    mode_d     = mode_q;
    if (state_q == IDLE && start) begin
      mode_d  = mode;
      cnt_d   = '0;
      shreg_d = mode ? '0 : data_in;
    end else if (state_q == SHIFT && !abort) begin
      shreg_d = {mode_q & serial_in, shreg_q[NBITS-1:1]};
      cnt_d   = cnt_q + 1'b1;
      if (last_shift && mode_q) data_out_d = {serial_in, shreg_q[NBITS-1:1]};
    end
  end

  always_ff @(posedge clk_2 or posedge reset) begin
    if (reset) begin
      shreg_q    <= '0;
      data_out_q <= '0;
      cnt_q      <= '0;
      mode_q     <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      data_out_q <= data_out_d;
      cnt_q      <= cnt_d;
      mode_q     <= mode_d;
    end
  end

endmodule

// File: tb/tb_shift_link_ctrl.sv
// Bench for shift_link_ctrl: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a transfer-level model (bit position within the current transfer).
module tb_shift_link_ctrl;

  localparam int NB = 4;
  localparam int CW = $clog2(NB);

  logic          clk_2 = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          mode = 1'b0;
  logic          abort = 1'b0;
  logic [NB-1:0] data_in = '0;
  logic          serial_in = 1'b0;
  logic          serial_out;
  logic [NB-1:0] data_out;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;
  logic [CW-1:0] count_dbg;

  int errors = 0;
  int checks = 0;

  shift_link_ctrl #(.NBITS(NB)) dut (
    .clk_2(clk_2), .reset(reset), .start(start), .mode(mode), .abort(abort),
    .data_in(data_in), .serial_in(serial_in), .serial_out(serial_out),
    .data_out(data_out), .busy(busy), .done(done),
    .state_dbg(state_dbg), .count_dbg(count_dbg)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: m_pos = -1 idle, 0..NB-1 = index of the bit in flight, NB = done cycle.
  int            m_pos = -1;
  logic [NB-1:0] m_tx = '0;
  int            m_rx = 0;
  logic          m_rxmode = 1'b0;
  int            m_dout = 0;

  initial forever begin
    @(posedge clk_2 or posedge reset);
    if (reset) begin
      m_pos = -1;
      m_dout = 0;
    end else if (m_pos < 0) begin
      if (start) begin
        m_rxmode = mode;
        m_tx = data_in;
        m_rx = 0;
        m_pos = 0;
      end
    end else if (m_pos < NB) begin
      if (abort) begin
        m_pos = -1;
      end else begin
        if (m_rxmode) m_rx = m_rx | (int'(serial_in) << m_pos);
        m_pos++;
        if (m_pos == NB && m_rxmode) m_dout = m_rx;
      end
    end else begin
      m_pos = -1;
    end
  end

  initial forever begin
    @(negedge clk_2);
    if (!reset) begin
      chk("model_busy", int'(busy), int'(m_pos >= 0));
      chk("model_done", int'(done), int'(m_pos == NB));
      chk("model_state", int'(state_dbg), (m_pos < 0) ? 0 : (m_pos < NB) ? 1 : 2);
      chk("model_sout", int'(serial_out),
          (m_pos >= 0 && m_pos < NB && !m_rxmode) ? int'(m_tx[m_pos]) : 0);
      chk("model_dout", int'(data_out), m_dout);
      if (m_pos >= 0 && m_pos < NB) chk("model_count", int'(count_dbg), m_pos);
    end
  end

  logic [NB-1:0] sov;
  logic [NB:0]   bv, dv;
  logic [NB-1:0] bits;
  int            ndone;
  int            seq [0:6];

  task automatic rx_xfer(input logic [NB-1:0] b);
    start = 1'b1; mode = 1'b1;
    for (int i = 0; i <= NB; i++) begin
      @(negedge clk_2);
      start = 1'b0;
      if (i < NB) serial_in = b[i];
      else chk("rx_sout_done", int'(serial_out), 0);
      if (i < NB) chk("rx_sout", int'(serial_out), 0);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk_2);
    #1;
    chk("rst_state", int'(state_dbg), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_sout", int'(serial_out), 0);
    chk("rst_dout", int'(data_out), 0);
    chk("rst_count", int'(count_dbg), 0);
    @(negedge clk_2);
    reset = 1'b0;
    @(negedge clk_2);

    // TX 1011, single-cycle start
    start = 1'b1; mode = 1'b0; data_in = 4'b1011;
    for (int i = 0; i <= NB; i++) begin
      @(negedge clk_2);
      start = 1'b0; data_in = '0;
      if (i < NB) sov[i] = serial_out;
      bv[i] = busy; dv[i] = done;
    end
    chk("tx_bits", int'(sov), 4'b1011);
    chk("tx_busy", int'(bv), 5'b11111);
    chk("tx_done", int'(dv), 5'b10000);
    chk("tx_dout", int'(data_out), 0);
    @(negedge clk_2);

    // RX receiving 1,1,0,0
    bits = 4'b0011;
    rx_xfer(bits);
    chk("rx_done_flag", int'(done), 1);
    chk("rx_dout", int'(data_out), 4'b0011);
    @(negedge clk_2);
    chk("rx_dout_hold", int'(data_out), 4'b0011);

    // start held high, TX 0xA
    start = 1'b1; mode = 1'b0; data_in = 4'hA; ndone = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk_2);
      if (done) ndone++;
      if (i < NB) sov[i] = serial_out;
      if (i >= 6 && i < 6 + NB) bv[i-6] = serial_out;
    end
    start = 1'b0;
    chk("held_done_cnt", ndone, 3);
    chk("held_bits0", int'(sov), 4'b1010);
    chk("held_bits1", int'(bv[NB-1:0]), 4'b1010);
    repeat (3) @(negedge clk_2);

    // start pulsed during SHIFT and DONE
    seq[0] = int'(state_dbg);
    start = 1'b1; mode = 1'b0; data_in = 4'h5; ndone = 0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk_2);
      seq[i] = int'(state_dbg);
      if (done) ndone++;
      start = (i == 1 || i == 4);
    end
    start = 1'b0;
    chk("ign_done_cnt", ndone, 1);
    chk("ign_s0", seq[0], 0); chk("ign_s1", seq[1], 1); chk("ign_s2", seq[2], 1);
    chk("ign_s3", seq[3], 1); chk("ign_s4", seq[4], 1); chk("ign_s5", seq[5], 2);
    chk("ign_s6", seq[6], 0);

    // RX 0110, then RX aborted after two shifts
    bits = 4'b0110;
    rx_xfer(bits);
    chk("rx2_dout", int'(data_out), 4'b0110);
    @(negedge clk_2);
    start = 1'b1; mode = 1'b1; serial_in = 1'b1;
    @(negedge clk_2); start = 1'b0;
    @(negedge clk_2);
    @(negedge clk_2); abort = 1'b1;
    @(negedge clk_2); abort = 1'b0;
    chk("abort_state", int'(state_dbg), 0);
    chk("abort_done", int'(done), 0);
    chk("abort_dout", int'(data_out), 4'b0110);
    @(negedge clk_2);
    chk("abort_no_done", int'(done), 0);

    // async reset between edges, mid-SHIFT
    start = 1'b1; mode = 1'b0; data_in = 4'hF;
    @(negedge clk_2); start = 1'b0;
    @(negedge clk_2);
    #2 reset = 1'b1;
    #1;
    chk("arst_state", int'(state_dbg), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_dout", int'(data_out), 0);
    chk("arst_sout", int'(serial_out), 0);
    @(negedge clk_2); reset = 1'b0;
    @(negedge clk_2);
    start = 1'b1; mode = 1'b0; data_in = 4'b0110;
    for (int i = 0; i <= NB; i++) begin
      @(negedge clk_2);
      start = 1'b0;
      if (i < NB) sov[i] = serial_out;
      dv[i] = done;
    end
    chk("post_rst_bits", int'(sov), 4'b0110);
    chk("post_rst_done", int'(dv), 5'b10000);

    // randomized traffic, checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk_2);
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 499) == 0) reset = 1'b1;
      start     = ($urandom_range(0, 3) == 0);
      mode      = 1'($urandom);
      abort     = ($urandom_range(0, 15) == 0);
      data_in   = NB'($urandom);
      serial_in = 1'($urandom);
    end
    @(negedge clk_2);
    reset = 1'b0; start = 1'b0; abort = 1'b0;
    repeat (2) @(negedge clk_2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
